// File: rtl/vga_fb_mem_arbiter_if.sv
// vga_fb_mem_arbiter_if: requester handshakes (display read, draw write) plus PSRAM pin bundle; slave = arbiter side, master = requesters/RAM side
interface vga_fb_mem_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ack;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_be;
  logic              wr_ack;
  logic              busy;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_dq_o;
  logic [DATA_W-1:0] mem_dq_i;
  logic              mem_dq_oe;
  logic              mem_oe_n;
  logic              mem_we_n;
  logic              ram_cs_n;
  logic              ram_lb_n;
  logic              ram_ub_n;
  logic              ram_adv_n;
  logic              ram_cre;
  logic              ram_clk;
  modport slave (
    input  disp_req, disp_addr, wr_req, wr_addr, wr_data, wr_be, mem_dq_i,
    output disp_ack, disp_rdata, disp_rvalid, wr_ack, busy, mem_adr, mem_dq_o, mem_dq_oe,
           mem_oe_n, mem_we_n, ram_cs_n, ram_lb_n, ram_ub_n, ram_adv_n, ram_cre, ram_clk
  );
  modport master (
    output disp_req, disp_addr, wr_req, wr_addr, wr_data, wr_be, mem_dq_i,
    input  disp_ack, disp_rdata, disp_rvalid, wr_ack, busy, mem_adr, mem_dq_o, mem_dq_oe,
           mem_oe_n, mem_we_n, ram_cs_n, ram_lb_n, ram_ub_n, ram_adv_n, ram_cre, ram_clk
  );
endinterface

// File: rtl/vga_fb_mem_arbiter.sv
// vga_fb_mem_arbiter: shares async PSRAM between display line-fetch (priority, bounded run) and draw writes; ports: clk, rst, bus (slave)
module vga_fb_mem_arbiter #(
  parameter int ADDR_W        = 23,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 4,
  parameter int TURN_CYCLES   = 1,
  parameter int DISP_MAX_RUN  = 8
) (
  input logic                 clk,
  input logic                 rst,
  vga_fb_mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(ACCESS_CYCLES + TURN_CYCLES + 1);
  localparam int RW = $clog2(DISP_MAX_RUN + 1);
  typedef enum logic [1:0] {IDLE, RD, WR, TURN} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] run;
  logic          grant_rd, grant_wr, done;
  assign bus.ram_adv_n = 1'b0;
  assign bus.ram_cre   = 1'b0;
  assign bus.ram_clk   = 1'b0;
  always_comb begin
    grant_wr = state == IDLE && bus.wr_req && (!bus.disp_req || run == RW'(DISP_MAX_RUN));
    grant_rd = state == IDLE && bus.disp_req && !grant_wr;
    done     = (state == RD || state == WR) && cnt == CW'(ACCESS_CYCLES - 1);
    state_n  = grant_rd ? RD :
               grant_wr ? WR :
               done ? (TURN_CYCLES > 0 ? TURN : IDLE) :
               (state == TURN && cnt == CW'(TURN_CYCLES - 1)) ? IDLE : state;
    cnt_n    = (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      run             <= '0;
      bus.disp_ack    <= 1'b0;
      bus.disp_rvalid <= 1'b0;
      bus.disp_rdata  <= '0;
      bus.wr_ack      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.mem_adr     <= '0;
      bus.mem_dq_o    <= '0;
      bus.mem_dq_oe   <= 1'b0;
      bus.mem_oe_n    <= 1'b1;
      bus.mem_we_n    <= 1'b1;
      bus.ram_cs_n    <= 1'b1;
      bus.ram_lb_n    <= 1'b1;
      bus.ram_ub_n    <= 1'b1;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      run             <= (!bus.wr_req || grant_wr) ? '0 : grant_rd ? run + 1'b1 : run;
      bus.busy        <= state_n != IDLE;
      bus.disp_ack    <= grant_rd;
      bus.wr_ack      <= done && state == WR;
      bus.disp_rvalid <= done && state == RD;
      if (done && state == RD) bus.disp_rdata <= bus.mem_dq_i;
      if (grant_rd || grant_wr) begin
        bus.mem_adr   <= grant_wr ? bus.wr_addr : bus.disp_addr;
        bus.ram_cs_n  <= 1'b0;
        bus.mem_oe_n  <= !grant_rd;
        bus.mem_we_n  <= !grant_wr;
        bus.mem_dq_oe <= grant_wr;
        bus.ram_lb_n  <= grant_wr && !bus.wr_be[0];
        bus.ram_ub_n  <= grant_wr && !bus.wr_be[1];
        if (grant_wr) bus.mem_dq_o <= bus.wr_data;
      end else if (done) begin
        bus.ram_cs_n  <= 1'b1;
        bus.mem_oe_n  <= 1'b1;
        bus.mem_we_n  <= 1'b1;
        bus.mem_dq_oe <= 1'b0;
        bus.ram_lb_n  <= 1'b1;
        bus.ram_ub_n  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_fb_mem_arbiter.sv
// tb_vga_fb_mem_arbiter: directed table and sequence checks of the PSRAM arbiter against a 70 ns async RAM model
module tb_vga_fb_mem_arbiter;
  typedef struct {
    logic        wr;
    logic [22:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem [0:4095];
  int          checks = 0;
  int          fails = 0;
  int          ovl = 0;
  vec_t        vecs [8];
  vga_fb_mem_arbiter_if #(.ADDR_W(23), .DATA_W(16)) bus ();
  vga_fb_mem_arbiter #(.DISP_MAX_RUN(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #10 clk = ~clk;
  always @(bus.mem_oe_n) begin
    bus.mem_dq_i = 16'h0BAD;
    if (!bus.mem_oe_n) begin
      #70;
      if (!bus.mem_oe_n) bus.mem_dq_i = mem[bus.mem_adr[11:0]];
    end
  end
  always @(negedge clk) begin
    if (!bus.ram_cs_n && !bus.mem_we_n) begin
      if (!bus.ram_lb_n) mem[bus.mem_adr[11:0]][7:0] = bus.mem_dq_o[7:0];
      if (!bus.ram_ub_n) mem[bus.mem_adr[11:0]][15:8] = bus.mem_dq_o[15:8];
    end
    if ((!bus.mem_oe_n && !bus.mem_we_n) || (bus.mem_dq_oe && !bus.mem_oe_n)) ovl++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic txn(input vec_t v, input int idx);
    int          s0 = -1, ns = 0, ack_c = -1, rv_c = -1, idle_c = -1, oe_c = 0;
    logic [22:0] adr = '0;
    logic        lb = 1'b1, ub = 1'b1, dqok = 1'b1, strobe;
    logic [15:0] rd = '0;
    if (v.wr) begin
      bus.wr_addr = v.addr;
      bus.wr_data = v.data;
      bus.wr_be   = v.be;
      bus.wr_req  = 1'b1;
    end else begin
      bus.disp_addr = v.addr;
      bus.disp_req  = 1'b1;
    end
    for (int k = 0; k < 40 && idle_c < 0; k++) begin
      @(negedge clk);
      strobe = v.wr ? !bus.mem_we_n : !bus.mem_oe_n;
      if (strobe) begin
        if (s0 < 0) begin
          s0  = k;
          adr = bus.mem_adr;
          lb  = bus.ram_lb_n;
          ub  = bus.ram_ub_n;
        end
        ns++;
        if (bus.mem_dq_oe !== v.wr || bus.ram_cs_n !== 1'b0 || (v.wr && bus.mem_dq_o !== v.data)) dqok = 1'b0;
      end
      if (bus.mem_dq_oe) oe_c++;
      if (v.wr ? bus.wr_ack : bus.disp_ack) begin
        ack_c = k;
        if (v.wr) bus.wr_req = 1'b0;
        else bus.disp_req = 1'b0;
      end
      if (bus.disp_rvalid) begin
        rv_c = k;
        rd   = bus.disp_rdata;
      end
      if (s0 >= 0 && !bus.busy) idle_c = k;
    end
    bus.wr_req   = 1'b0;
    bus.disp_req = 1'b0;
    chk($sformatf("v%0d_started", idx), 32'(s0 >= 0), 1);
    chk($sformatf("v%0d_strobe_cycles", idx), ns, 4);
    chk($sformatf("v%0d_ack_offset", idx), ack_c - s0, v.wr ? 4 : 0);
    chk($sformatf("v%0d_mem_adr", idx), 32'(adr), 32'(v.addr));
    chk($sformatf("v%0d_ub_lb", idx), {ub, lb}, v.wr ? {!v.be[1], !v.be[0]} : 2'b00);
    chk($sformatf("v%0d_dq_cs", idx), 32'(dqok), 1);
    chk($sformatf("v%0d_dq_oe_cycles", idx), oe_c, v.wr ? 4 : 0);
    chk($sformatf("v%0d_idle_offset", idx), idle_c - s0, 5);
    if (v.wr) chk($sformatf("v%0d_mem_word", idx), 32'(mem[v.addr[11:0]]), 32'(v.exp));
    else begin
      chk($sformatf("v%0d_rvalid_offset", idx), rv_c - s0, 4);
      chk($sformatf("v%0d_rdata", idx), 32'(rd), 32'(v.exp));
    end
  endtask
  initial begin
    int          c1, nack, ng, busy_c;
    logic [9:0]  gr;
    logic        prev_we, seen_ack;
    vecs[0] = '{1'b1, 23'h0004AA, 16'h1234, 2'b10, 16'h1278};
    vecs[1] = '{1'b1, 23'h000123, 16'hBEEF, 2'b11, 16'hBEEF};
    vecs[2] = '{1'b0, 23'h000123, 16'h0000, 2'b00, 16'hBEEF};
    vecs[3] = '{1'b0, 23'h0004AA, 16'h0000, 2'b00, 16'h1278};
    vecs[4] = '{1'b1, 23'h000010, 16'hFFFF, 2'b00, 16'hA5A5};
    vecs[5] = '{1'b1, 23'h000011, 16'hCAFE, 2'b01, 16'h11FE};
    vecs[6] = '{1'b0, 23'h000010, 16'h0000, 2'b00, 16'hA5A5};
    vecs[7] = '{1'b0, 23'h7FF0AA, 16'h0000, 2'b00, 16'h3C3C};
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h4AA] = 16'h5678;
    mem[12'h010] = 16'hA5A5;
    mem[12'h011] = 16'h1111;
    mem[12'h0AA] = 16'h3C3C;
    bus.mem_dq_i  = 16'h0BAD;
    bus.disp_req  = 1'b1;
    bus.disp_addr = 23'h000200;
    bus.wr_req    = 1'b1;
    bus.wr_addr   = 23'h000201;
    bus.wr_data   = 16'h7777;
    bus.wr_be     = 2'b11;
    rst           = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst%0d_strobes", i), {bus.ram_cs_n, bus.mem_oe_n, bus.mem_we_n, bus.ram_lb_n, bus.ram_ub_n}, 5'b11111);
      chk($sformatf("rst%0d_oe_ack_busy", i), {bus.mem_dq_oe, bus.disp_ack, bus.wr_ack, bus.disp_rvalid, bus.busy}, 5'b00000);
      chk($sformatf("rst%0d_adr", i), 32'(bus.mem_adr), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("first_grant_disp_ack", 32'(bus.disp_ack), 1);
    bus.disp_req = 1'b0;
    c1       = -1;
    seen_ack = 1'b0;
    for (int k = 1; k < 30 && !seen_ack; k++) begin
      @(negedge clk);
      if (!bus.mem_we_n && c1 < 0) c1 = k;
      if (bus.wr_ack) begin
        seen_ack   = 1'b1;
        bus.wr_req = 1'b0;
      end
    end
    chk("simul_write_grant_gap", c1, 6);
    chk("simul_wr_ack_seen", 32'(seen_ack), 1);
    chk("simul_mem_word", 32'(mem[12'h201]), 32'h7777);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) txn(vecs[i], i);
    bus.wr_addr = 23'h000005;
    bus.wr_data = 16'h9999;
    bus.wr_be   = 2'b11;
    bus.wr_req  = 1'b1;
    c1 = -1;
    for (int k = 0; k < 20 && c1 < 0; k++) begin
      @(negedge clk);
      if (!bus.mem_we_n) c1 = k;
    end
    chk("abort_write_started", 32'(c1 >= 0), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we_n", 32'(bus.mem_we_n), 1);
    chk("abort_dq_oe", 32'(bus.mem_dq_oe), 0);
    chk("abort_cs_n_busy", {bus.ram_cs_n, bus.busy}, 2'b10);
    rst        = 1'b0;
    bus.wr_req = 1'b0;
    nack   = 0;
    busy_c = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.wr_ack) nack++;
      if (bus.busy) busy_c++;
    end
    chk("abort_no_wr_ack", nack, 0);
    chk("abort_stays_idle", busy_c, 0);
    bus.disp_addr = 23'h000123;
    bus.wr_addr   = 23'h000300;
    bus.wr_data   = 16'h4242;
    bus.wr_be     = 2'b11;
    bus.disp_req  = 1'b1;
    bus.wr_req    = 1'b1;
    gr      = '0;
    ng      = 0;
    nack    = 0;
    prev_we = 1'b1;
    for (int k = 0; k < 200 && ng < 10; k++) begin
      @(negedge clk);
      if (bus.disp_ack) begin
        gr[ng] = 1'b0;
        ng++;
      end
      if (!bus.mem_we_n && prev_we && ng < 10) begin
        gr[ng] = 1'b1;
        ng++;
      end
      prev_we = bus.mem_we_n;
      if (bus.wr_ack) nack++;
    end
    bus.disp_req = 1'b0;
    bus.wr_req   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.wr_ack) nack++;
    end
    chk("starve_grant_count", ng, 10);
    chk("starve_grant_order", 32'(gr), 32'(10'b1000010000));
    chk("starve_wr_ack_count", nack, 2);
    chk("strobe_overlap", ovl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
